// File: rtl/datapath_sequencer_if.sv
// Control bundle between datapath_sequencer and the single-bus datapath.
// The step signal exists only when SEQ_SINGLE_STEP_EN is defined.
interface datapath_sequencer_if #(parameter int OPW = 5);
    logic            run;
    logic [31:0]     ir;
    logic            con_ff;
    logic            mem_ack;
`ifdef SEQ_SINGLE_STEP_EN
    logic            step;
`endif
    logic            mem_rd;
    logic            pc_out, zlo_out, zhi_out, mdr_out, c_out;
    logic            mar_in, pc_enable, pc_increment, mdr_enable, mdr_read, ir_enable;
    logic            y_enable, zlo_enable, zhi_enable, lo_enable, hi_enable, con_enable;
    logic            gra, grb, grc, r_in, r_out, ba_out;
    logic [OPW-1:0]  op_code;
    logic            halted;
    logic            fault;

    modport master (
`ifdef SEQ_SINGLE_STEP_EN
        input  step,
`endif
        input  run, ir, con_ff, mem_ack,
        output mem_rd, pc_out, zlo_out, zhi_out, mdr_out, c_out,
        output mar_in, pc_enable, pc_increment, mdr_enable, mdr_read, ir_enable,
        output y_enable, zlo_enable, zhi_enable, lo_enable, hi_enable, con_enable,
        output gra, grb, grc, r_in, r_out, ba_out, op_code, halted, fault
    );

    modport slave (
`ifdef SEQ_SINGLE_STEP_EN
        output step,
`endif
        output run, ir, con_ff, mem_ack,
        input  mem_rd, pc_out, zlo_out, zhi_out, mdr_out, c_out,
        input  mar_in, pc_enable, pc_increment, mdr_enable, mdr_read, ir_enable,
        input  y_enable, zlo_enable, zhi_enable, lo_enable, hi_enable, con_enable,
        input  gra, grb, grc, r_in, r_out, ba_out, op_code, halted, fault
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the single-bus datapath.
// Optional single-step mode (STEP state, step input) under SEQ_SINGLE_STEP_EN.
module datapath_sequencer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int OPW          = 5
) (
    input logic                   clk,
    input logic                   clr,
    datapath_sequencer_if.master  bus
);
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef SEQ_SINGLE_STEP_EN
        , S_STEP
`endif
    } state_t;

    typedef enum logic [2:0] {C_ALU3, C_ALUI, C_MULDIV, C_LD, C_BR} cls_t;

    state_t          state;
    state_t          after_last;
    cls_t            cls;
    logic [4:0]      opc;
    logic [CW-1:0]   wait_cnt;
    logic            halted_q;
    logic            fault_q;
    logic            memw;

    assign memw = (state == S_T1) || (state == S_T6 && cls == C_LD);

    always_comb begin
`ifdef SEQ_SINGLE_STEP_EN
        after_last = S_STEP;
`else
        after_last = bus.run ? S_T0 : S_IDLE;
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_IDLE;
            cls      <= C_ALU3;
            opc      <= '0;
            wait_cnt <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            // counter only survives consecutive un-acked MEMW cycles
            wait_cnt <= '0;
            case (state)
                S_IDLE: if (bus.run) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1: begin
                    if (bus.mem_ack) begin
                        state <= S_T2;
                    end else if (wait_cnt == CW'(MEM_WAIT_MAX)) begin
                        state    <= S_HALT;
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_T2:   state <= S_DEC;
                S_DEC: begin
                    opc <= bus.ir[31:27];
                    case (bus.ir[31:27]) inside
                        [5'd0:5'd9]:   begin cls <= C_ALU3;   state <= S_T3; end
                        [5'd10:5'd12]: begin cls <= C_ALUI;   state <= S_T3; end
                        [5'd13:5'd14]: begin cls <= C_MULDIV; state <= S_T3; end
                        5'd15:         begin cls <= C_LD;     state <= S_T3; end
                        5'd18:         begin cls <= C_BR;     state <= S_T3; end
                        5'd30:         state <= after_last;
                        5'd31:         begin state <= S_HALT; halted_q <= 1'b1; end
                        default: begin
                            state    <= S_HALT;
                            fault_q  <= 1'b1;
                            halted_q <= 1'b1;
                        end
                    endcase
                end
                S_T3:   state <= S_T4;
                S_T4:   state <= S_T5;
                S_T5:   state <= (cls == C_ALU3 || cls == C_ALUI) ? after_last : S_T6;
                S_T6: begin
                    if (cls != C_LD) begin
                        state <= after_last;
                    end else if (bus.mem_ack) begin
                        state <= S_T7;
                    end else if (wait_cnt == CW'(MEM_WAIT_MAX)) begin
                        state    <= S_HALT;
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_T7:   state <= after_last;
                S_HALT: state <= S_HALT;
`ifdef SEQ_SINGLE_STEP_EN
                S_STEP: begin
                    if (!bus.run)     state <= S_IDLE;
                    else if (bus.step) state <= S_T0;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_rd       = memw;
        bus.mdr_read     = memw & bus.mem_ack;
        bus.mdr_enable   = memw & bus.mem_ack;
        bus.pc_out       = 1'b0;
        bus.zlo_out      = 1'b0;
        bus.zhi_out      = 1'b0;
        bus.mdr_out      = 1'b0;
        bus.c_out        = 1'b0;
        bus.mar_in       = 1'b0;
        bus.pc_enable    = 1'b0;
        bus.pc_increment = 1'b0;
        bus.ir_enable    = 1'b0;
        bus.y_enable     = 1'b0;
        bus.zlo_enable   = 1'b0;
        bus.zhi_enable   = 1'b0;
        bus.lo_enable    = 1'b0;
        bus.hi_enable    = 1'b0;
        bus.con_enable   = 1'b0;
        bus.gra          = 1'b0;
        bus.grb          = 1'b0;
        bus.grc          = 1'b0;
        bus.r_in         = 1'b0;
        bus.r_out        = 1'b0;
        bus.ba_out       = 1'b0;
        bus.op_code      = '0;
        case (state)
            S_T0: begin
                bus.pc_out = 1'b1; bus.mar_in = 1'b1; bus.pc_increment = 1'b1;
            end
            S_T2: begin
                bus.mdr_out = 1'b1; bus.ir_enable = 1'b1;
            end
            S_T3: begin
                bus.r_out    = (cls != C_BR);
                bus.y_enable = (cls != C_BR);
                bus.gra      = (cls == C_MULDIV) || (cls == C_BR);
                bus.grb      = (cls == C_ALU3) || (cls == C_ALUI) || (cls == C_LD);
                bus.ba_out   = (cls == C_LD);
                if (cls == C_BR) begin
                    bus.r_out = 1'b1; bus.con_enable = 1'b1;
                end
            end
            S_T4: begin
                case (cls)
                    C_ALU3:   begin bus.grc = 1'b1; bus.r_out = 1'b1; end
                    C_MULDIV: begin bus.grb = 1'b1; bus.r_out = 1'b1; bus.zhi_enable = 1'b1; end
                    C_BR:     begin bus.pc_out = 1'b1; bus.y_enable = 1'b1; end
                    default:  bus.c_out = 1'b1;
                endcase
                bus.zlo_enable = (cls != C_BR);
                if (cls == C_ALU3 || cls == C_ALUI || cls == C_MULDIV)
                    bus.op_code = OPW'(opc);
            end
            S_T5: begin
                case (cls)
                    C_MULDIV: begin bus.zlo_out = 1'b1; bus.lo_enable = 1'b1; end
                    C_LD:     begin bus.zlo_out = 1'b1; bus.mar_in = 1'b1; end
                    C_BR:     begin bus.c_out = 1'b1; bus.zlo_enable = 1'b1; end
                    default:  begin bus.zlo_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1; end
                endcase
            end
            S_T6: begin
                if (cls == C_MULDIV) begin
                    bus.zhi_out = 1'b1; bus.hi_enable = 1'b1;
                end else if (cls == C_BR && bus.con_ff) begin
                    bus.zlo_out = 1'b1; bus.pc_enable = 1'b1;
                end
            end
            S_T7: begin
                bus.mdr_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.halted = halted_q;
    assign bus.fault  = fault_q;
endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench: stimulus pushes the hand-computed strobe vector per cycle,
// a negedge monitor pops and compares it against the packed DUT outputs.
module tb_datapath_sequencer;
    localparam logic [30:0] MEM_RD  = 31'd1 << 30;
    localparam logic [30:0] PC_OUT  = 31'd1 << 29;
    localparam logic [30:0] ZLO_OUT = 31'd1 << 28;
    localparam logic [30:0] ZHI_OUT = 31'd1 << 27;
    localparam logic [30:0] MDR_OUT = 31'd1 << 26;
    localparam logic [30:0] C_OUT   = 31'd1 << 25;
    localparam logic [30:0] MAR_IN  = 31'd1 << 24;
    localparam logic [30:0] PC_EN   = 31'd1 << 23;
    localparam logic [30:0] PC_INC  = 31'd1 << 22;
    localparam logic [30:0] MDR_EN  = 31'd1 << 21;
    localparam logic [30:0] MDR_RD  = 31'd1 << 20;
    localparam logic [30:0] IR_EN   = 31'd1 << 19;
    localparam logic [30:0] Y_EN    = 31'd1 << 18;
    localparam logic [30:0] ZLO_EN  = 31'd1 << 17;
    localparam logic [30:0] ZHI_EN  = 31'd1 << 16;
    localparam logic [30:0] LO_EN   = 31'd1 << 15;
    localparam logic [30:0] HI_EN   = 31'd1 << 14;
    localparam logic [30:0] CON_EN  = 31'd1 << 13;
    localparam logic [30:0] GRA     = 31'd1 << 12;
    localparam logic [30:0] GRB     = 31'd1 << 11;
    localparam logic [30:0] GRC     = 31'd1 << 10;
    localparam logic [30:0] R_IN    = 31'd1 << 9;
    localparam logic [30:0] R_OUT   = 31'd1 << 8;
    localparam logic [30:0] BA_OUT  = 31'd1 << 7;
    localparam logic [30:0] HALTED  = 31'd1 << 6;
    localparam logic [30:0] FAULT   = 31'd1 << 5;
    localparam logic [30:0] T0_V    = PC_OUT | MAR_IN | PC_INC;

    typedef struct {
        logic [30:0] v;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic run_lv = 1'b0;
    logic clr_lv = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic [30:0] obs;

    datapath_sequencer_if #(.OPW(5)) bus ();

    datapath_sequencer #(.MEM_WAIT_MAX(15), .OPW(5)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.mem_rd, bus.pc_out, bus.zlo_out, bus.zhi_out, bus.mdr_out, bus.c_out,
                  bus.mar_in, bus.pc_enable, bus.pc_increment, bus.mdr_enable, bus.mdr_read,
                  bus.ir_enable, bus.y_enable, bus.zlo_enable, bus.zhi_enable, bus.lo_enable,
                  bus.hi_enable, bus.con_enable, bus.gra, bus.grb, bus.grc, bus.r_in,
                  bus.r_out, bus.ba_out, bus.halted, bus.fault, bus.op_code};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL %s @%0t: got=%08h expected=%08h", e.nm, $time, obs, e.v);
            end
        end
    end

    // One clock: apply inputs just after the edge and queue this cycle's expectation.
    task automatic cyc(input logic ack, input logic [30:0] v, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        bus.run     = run_lv;
        clr         = clr_lv;
        bus.mem_ack = ack;
        e.v  = v;
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        clr         = 1'b1;
        bus.mem_ack = 1'b0;
        clr_lv      = 1'b0;
        cyc(1'b0, '0, "reset");
    endtask

    task automatic fetch(input logic [4:0] opc, input int waits, input logic noise);
        cyc(noise, T0_V, "t0");
        bus.ir = {opc, 27'h0123456};
        for (int i = 0; i < waits; i++) cyc(1'b0, MEM_RD, "memw_wait");
        cyc(1'b1, MEM_RD | MDR_RD | MDR_EN, "memw_ack");
        cyc(noise, MDR_OUT | IR_EN, "t2");
        cyc(noise, '0, "dec");
    endtask

    task automatic alu(input logic [4:0] opc, input logic imm);
        cyc(1'b0, GRB | R_OUT | Y_EN, "alu_t3");
        cyc(1'b0, (imm ? C_OUT : (GRC | R_OUT)) | ZLO_EN | {26'd0, opc}, "alu_t4");
        cyc(1'b0, ZLO_OUT | GRA | R_IN, "alu_t5");
    endtask

    task automatic ld_front();
        cyc(1'b0, GRB | R_OUT | BA_OUT | Y_EN, "ld_t3");
        cyc(1'b0, C_OUT | ZLO_EN, "ld_t4");
        cyc(1'b0, ZLO_OUT | MAR_IN, "ld_t5");
    endtask

    task automatic br(input logic cond);
        bus.con_ff = cond;
        cyc(1'b0, GRA | R_OUT | CON_EN, "br_t3");
        cyc(1'b0, PC_OUT | Y_EN, "br_t4");
        cyc(1'b0, C_OUT | ZLO_EN, "br_t5");
        cyc(1'b0, cond ? (ZLO_OUT | PC_EN) : 31'd0, "br_t6");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got=running expected=done");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.run = 1'b0;
        bus.ir = '0;
        bus.con_ff = 1'b0;
        bus.mem_ack = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        bus.step = 1'b1;
`endif
        repeat (2) @(posedge clk);

        run_lv = 1'b1;
        do_reset();
        fetch(5'd3, 0, 1'b0);           // ALU3, zero wait
        alu(5'd3, 1'b0);
        fetch(5'd11, 4, 1'b1);          // ALUI, 4 wait states, ack noise outside MEMW
        alu(5'd11, 1'b1);
        fetch(5'd14, 0, 1'b0);          // MULDIV
        cyc(1'b0, GRA | R_OUT | Y_EN, "mul_t3");
        cyc(1'b0, GRB | R_OUT | ZLO_EN | ZHI_EN | 31'd14, "mul_t4");
        cyc(1'b0, ZLO_OUT | LO_EN, "mul_t5");
        cyc(1'b0, ZHI_OUT | HI_EN, "mul_t6");
        fetch(5'd15, 0, 1'b0);          // LD with 2 wait states in T6
        ld_front();
        cyc(1'b0, MEM_RD, "ld_t6_wait");
        cyc(1'b0, MEM_RD, "ld_t6_wait");
        cyc(1'b1, MEM_RD | MDR_RD | MDR_EN, "ld_t6_ack");
        cyc(1'b0, MDR_OUT | GRA | R_IN, "ld_t7");
        fetch(5'd18, 0, 1'b0);
        br(1'b1);
        fetch(5'd18, 0, 1'b0);
        br(1'b0);
        fetch(5'd30, 0, 1'b0);          // NOP chains straight into the next fetch

        fetch(5'd7, 0, 1'b0);           // run dropped mid-instruction
        run_lv = 1'b0;
        alu(5'd7, 1'b0);
        cyc(1'b0, '0, "idle_run_low");
        run_lv = 1'b1;
        cyc(1'b0, '0, "idle_restart");

        fetch(5'd31, 0, 1'b0);
        cyc(1'b0, HALTED, "halt_op");
        cyc(1'b1, HALTED, "halt_stay");
        do_reset();
        fetch(5'd20, 0, 1'b0);
        cyc(1'b0, HALTED | FAULT, "illegal_op");
        cyc(1'b0, HALTED | FAULT, "illegal_stay");

        do_reset();                     // memory timeout in fetch
        cyc(1'b0, T0_V, "t0");
        for (int i = 0; i < 16; i++) cyc(1'b0, MEM_RD, "memw_timeout");
        cyc(1'b1, HALTED | FAULT, "timeout_halt");
        cyc(1'b1, HALTED | FAULT, "timeout_stay");

        do_reset();                     // clr in the middle of the LD handshake
        fetch(5'd15, 0, 1'b0);
        ld_front();
        clr_lv = 1'b1;
        cyc(1'b0, MEM_RD, "ld_t6_before_clr");
        clr_lv = 1'b0;
        cyc(1'b0, '0, "clr_mid_ld");
        fetch(5'd3, 0, 1'b0);
        alu(5'd3, 1'b0);
        cyc(1'b0, T0_V, "t0_after_clr");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Hardwired control unit for the single-bus datapath.
- Runs the fetch cycle, decodes the opcode in IR[31:27], and steps the execute T-states for each instruction class.
- Drives every datapath strobe: bus-source selects, register enables, ALU op_code, gra/grb/grc/r_in/r_out/ba_out, con_enable.
- Performs a req/ack handshake with memory for every MDR load.

Parameters:
- MEM_WAIT_MAX, 15, maximum cycles waiting for mem_ack before fault.
- OPW, 5, op_code width.

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- run  in  1  level; 1 = allow fetch from IDLE.
- ir  in  32  IR contents (data_ir).
- con_ff  in  1  branch condition flip-flop output.
- mem_ack  in  1  memory read data valid on data_in.
- mem_rd  out  1  memory read request.
- pc_out, zlo_out, zhi_out, mdr_out, c_out  out  1 each  bus source selects.
- mar_in, pc_enable, pc_increment, mdr_enable, mdr_read, ir_enable, y_enable, zlo_enable, zhi_enable, lo_enable, hi_enable, con_enable  out  1 each  register load strobes.
- gra, grb, grc, r_in, r_out, ba_out  out  1 each  register-file select/encode controls.
- op_code  out  OPW  ALU operation.
- halted  out  1  sequencer stopped (HALT opcode or fault).
- fault  out  1  illegal opcode or memory timeout.

Behaviour:
- Reset: synchronous; state=IDLE, wait counter=0, halted=0, fault=0, all strobes 0, op_code=0.
- clr overrides everything, including mid-instruction and mid-wait; the pending mem_rd drops in the next cycle.
- Strobe decoding: all strobes are Moore-decoded from the state register. Exception: mdr_read and mdr_enable in MEMW are Mealy (gated by mem_ack). At most one bus source is asserted per cycle.

State machine (IDLE → T0 → T1/MEMW → T2 → DEC → EXn → T0 | IDLE | HALT):
- IDLE: all strobes 0; when run=1, go to T0.
- T0: pc_out, mar_in, pc_increment.
- T1/MEMW: mem_rd=1. When mem_ack=1 in the same cycle: mdr_read=1, mdr_enable=1, advance. Otherwise increment the wait counter. When counter==MEM_WAIT_MAX with no ack: fault=1, go to HALT.
- T2: mdr_out, ir_enable.
- DEC: no strobes; classify ir[31:27].

Execute sequences (opc = ir[31:27]):
- ALU3, opc 0–9:
  - T3: grb, r_out, y_enable.
  - T4: grc, r_out, op_code=opc, zlo_enable.
  - T5: zlo_out, gra, r_in.
- ALUI, opc 10–12: as ALU3, except T4 uses c_out instead of grc/r_out.
- MULDIV, opc 13–14:
  - T3: gra, r_out, y_enable.
  - T4: grb, r_out, op_code=opc, zlo_enable, zhi_enable.
  - T5: zlo_out, lo_enable.
  - T6: zhi_out, hi_enable.
- LD, opc 15:
  - T3: grb, r_out, ba_out, y_enable.
  - T4: c_out, op_code=0 (add), zlo_enable.
  - T5: zlo_out, mar_in.
  - T6: MEMW handshake, same rules as fetch.
  - T7: mdr_out, gra, r_in.
- BR, opc 18:
  - T3: gra, r_out, con_enable.
  - T4: pc_out, y_enable.
  - T5: c_out, op_code=0, zlo_enable.
  - T6: if con_ff=1, zlo_out and pc_enable; otherwise no strobe.
- NOP, opc 30: no execute states.
- HALT, opc 31: go to HALT; halted=1.
- Any other opcode: fault=1, go to HALT.

Completion and exit:
- After the last execute state: if run=1 go to T0, else IDLE.
- HALT is exited only by clr.

Latency:
- Fetch is 3 cycles plus memory wait states.
- DEC is 1 cycle.
- Execute is 3/3/4/5/4 cycles for ALU3/ALUI/MULDIV/LD/BR.

Boundary conditions:
- run deasserted mid-instruction: the instruction completes, then the sequencer goes to IDLE.
- mem_ack outside MEMW: ignored.
- The wait counter resets on entry to each MEMW.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined: adds input step (1-bit) and state STEP.
  - After each instruction's last state, the sequencer enters STEP with all strobes 0.
  - It leaves STEP to T0 on the first cycle with step=1 (a level, sampled once).
  - run=0 while in STEP sends it to IDLE.
- When undefined: no step port and no STEP state; instructions chain back-to-back as described above.

Test Plan:
- Fetch, zero wait: clr 1 cycle, run=1, mem_ack=1 in T1, ir=0x18000000 (opc 3). Expect pc_out+mar_in+pc_increment in cycle 1, mdr_read+mdr_enable in cycle 2, ir_enable in cycle 3, DEC, then T3/T4/T5 strobes with op_code=3; next T0 at cycle 8.
- Memory wait: hold mem_ack=0 for 4 cycles, then 1. Expect mem_rd high for 5 cycles and mdr_enable only in the 5th. Hold mem_ack=0 for 16 cycles: expect fault=1, halted=1, all strobes 0 thereafter.
- MULDIV, ir opc=14: expect zlo_enable and zhi_enable together in T4, lo_enable in T5, hi_enable in T6.
- Branch: opc=18 with con_ff=1, expect pc_enable and zlo_out in T6. Same with con_ff=0: expect no pc_enable.
- Illegal/halt: opc=20 → fault=1, HALT. opc=31 → halted=1, fault=0. Then clr → IDLE, outputs 0.
- Reset mid-LD: assert clr in T6 with mem_rd=1. Expect mem_rd=0 the next cycle and state IDLE; with run=1, a fresh fetch starts at T0.
